// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the non-restoring divider
package div_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/div_addsub.sv
// rtl/div_addsub.sv - combinational WIDTH+1-bit adder/subtractor shared by ITER and FIX
module div_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] y_o
);

  // Two's-complement wrap-around is intended; the sign bit carries the partial-remainder sign.
  always_comb begin
    if (sub_i) begin
      y_o = a_i - b_i;
    end else begin
      y_o = a_i + b_i;
    end
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - unsigned non-restoring divider, one quotient bit per cycle
// Optional feature: DIV_ZERO_DETECT_EN short-circuits a zero divisor from LOAD straight to DONE.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   as_a, as_b, as_y;
  logic             as_sub;
  logic [CW-1:0]    cnt_dec;

  // ITER feeds the shifted {A,Q}; FIX feeds A unchanged and always adds M back.
  always_comb begin
    as_b = {1'b0, m_q};
    if (state_q == FIX) begin
      as_a   = a_q;
      as_sub = 1'b0;
    end else begin
      as_a   = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      as_sub = ~a_q[WIDTH];
    end
  end

  div_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .y_o   (as_y)
  );

  assign cnt_dec = cnt_q - CW'(1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        a_d     = '0;
        q_d     = dividend;
        m_d     = divisor;
        cnt_d   = CW'(WIDTH);
        state_d = ITER;
`ifdef DIV_ZERO_DETECT_EN
        if (divisor == '0) begin
          quot_d  = '1;
          rem_d   = dividend;
          state_d = DONE;
        end
`endif
      end
      ITER: begin
        a_d   = as_y;
        q_d   = {q_q[WIDTH-2:0], ~as_y[WIDTH]};
        cnt_d = cnt_dec;
        if (cnt_dec == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Results are captured here so they are already valid in the DONE cycle.
        a_d     = a_q[WIDTH] ? as_y : a_q;
        quot_d  = q_q;
        rem_d   = a_q[WIDTH] ? as_y[WIDTH-1:0] : a_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = (state_q == LOAD) || (state_q == ITER) || (state_q == FIX);
  assign done      = (state_q == DONE);

`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      dbz_q <= 1'b0;
    end else if (state_q == LOAD) begin
      dbz_q <= (divisor == '0);
    end
  end

  assign div_by_zero = done & dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - directed and random self-checking bench for nonrestoring_divider
module tb_nonrestoring_divider;

  logic        clk;
  logic        clr;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks;
  int errors;

  nonrestoring_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for the sampling edge, then measure edges (inclusive of that edge) until done.
  task automatic run_div(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                         input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                         input logic ez);
    int lat;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (lat <= 100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    check({tag, "_busy_in_done"}, busy, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_q"}, quotient, eq);
  endtask

  initial begin
    int zlat;
    logic zdbz;
    int ndone;
    logic [15:0] rd, rv;
    checks   = 0;
    errors   = 0;
    clr      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_dbz", div_by_zero, 0);
    clr = 1'b0;

    run_div("basic_100_7", 16'd100, 16'd7, 19, 16'd14, 16'd2, 1'b0);
    run_div("ffff_1", 16'hFFFF, 16'd1, 19, 16'hFFFF, 16'd0, 1'b0);
    run_div("b2b_5_9", 16'd5, 16'd9, 19, 16'd0, 16'd5, 1'b0);
    run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 19, 16'd1, 16'd0, 1'b0);
    run_div("7_100", 16'd7, 16'd100, 19, 16'd0, 16'd7, 1'b0);
    run_div("8000_3", 16'h8000, 16'd3, 19, 16'd10922, 16'd2, 1'b0);

`ifdef DIV_ZERO_DETECT_EN
    zlat = 2;
    zdbz = 1'b1;
`else
    zlat = 19;
    zdbz = 1'b0;
`endif
    run_div("div_zero", 16'd1234, 16'd0, zlat, 16'hFFFF, 16'd1234, zdbz);

    // Clear during the 8th ITER cycle: edge 1 -> LOAD, edge 2 -> first ITER, edge 9 -> 8th ITER.
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_q", quotient, 0);
    check("clr_r", remainder, 0);
    check("clr_dbz", div_by_zero, 0);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("clr_no_done", ndone, 0);
    run_div("after_clr_50_5", 16'd50, 16'd5, 19, 16'd10, 16'd0, 1'b0);

    // start held high mid-operation with other operands must not disturb or queue.
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 16'd9;
    divisor  = 16'd3;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ignore_q", quotient, 14);
        check("ignore_r", remainder, 2);
      end
    end
    check("ignore_one_done", ndone, 1);
    check("ignore_idle", busy, 0);

    for (int i = 0; i < 20; i++) begin
      rd = 16'($urandom);
      rv = (i < 5) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      run_div("rand", rd, rv, 19, rd / rv, rd % rv, 1'b0);
      check("rand_identity", 32'(quotient) * 32'(rv) + 32'(remainder), 32'(rd));
      check("rand_rem_lt", remainder < rv, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned dividend; sampled in LOAD.
REQ-006 divisor  input  WIDTH  unsigned divisor; sampled in LOAD.
REQ-007 quotient  output  WIDTH  unsigned quotient, registered.
REQ-008 remainder  output  WIDTH  unsigned remainder, registered.
REQ-009 busy  output  1  high in LOAD, ITER and FIX.
REQ-010 done  output  1  one-cycle pulse; results are valid from this cycle onwards.
REQ-011 div_by_zero  output  1  high with done when the divisor was 0 (only when the macro in REQ-030 is defined).

Function
REQ-012 The block shall perform unsigned non-restoring division: quotient = dividend / divisor, remainder = dividend mod divisor.
REQ-013 Datapath registers:
  - A: WIDTH+1 bits, signed partial remainder.
  - Q: WIDTH bits, dividend shifting to quotient.
  - M: WIDTH bits, divisor.
  - Iteration counter: $clog2(WIDTH)+1 bits.
REQ-014 States: IDLE, LOAD, ITER, FIX, DONE.
REQ-015 State transitions:
  - IDLE -> LOAD when start=1; otherwise stay in IDLE.
  - LOAD -> ITER.
  - ITER -> ITER while count != 0 after decrement; ITER -> FIX on the last iteration.
  - FIX -> DONE.
  - DONE -> IDLE unconditionally.
REQ-016 LOAD shall set A=0, Q=dividend, M=divisor and count=WIDTH.
REQ-017 Each ITER cycle shall perform one step:
  - Shift {A,Q} left by 1.
  - If the old A[WIDTH]=1, A = shifted A + {0,M}; otherwise A = shifted A - {0,M}.
  - Q[0] = ~new A[WIDTH].
  - Decrement count.
REQ-018 FIX shall apply the correction A = A + {0,M} only if A[WIDTH]=1.
REQ-019 In DONE, quotient = Q and remainder = A[WIDTH-1:0], registered.
REQ-020 done shall be 1 only in DONE.
REQ-021 quotient and remainder shall hold their values until the next LOAD.
REQ-022 Latency: done shall be high WIDTH+3 rising edges after the edge that samples start (19 for WIDTH=16).
REQ-023 start while busy or done is high shall be ignored; no queuing.
REQ-024 Arithmetic shall be WIDTH+1 bits with wrap-around; no overflow is possible for unsigned operands.
REQ-025 A new start may be accepted on the cycle directly after DONE (back-to-back operation).

Reset
REQ-026 When clr=1 at a clock edge, state shall become IDLE from any state, including mid-ITER.
REQ-027 On reset, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, A=0, Q=0, M=0 and count=0.
REQ-028 An operation interrupted by clr shall produce no done pulse.
REQ-029 clr shall take priority over start.

Configuration
REQ-030 Macro DIV_ZERO_DETECT_EN.
REQ-031 With DIV_ZERO_DETECT_EN defined, a divisor of 0 shall be handled as follows:
  - LOAD -> DONE directly, skipping ITER and FIX.
  - quotient = all ones, remainder = dividend, div_by_zero=1 for the done cycle.
  - Latency is 2 edges.
REQ-032 Without DIV_ZERO_DETECT_EN:
  - div_by_zero shall be tied to 0.
  - A divisor of 0 shall run the full algorithm: WIDTH+3 latency, quotient = all ones, remainder = dividend.

Structure
REQ-033 Package div_pkg shall contain:
  - the state enumeration (IDLE, LOAD, ITER, FIX, DONE), 3-bit encoding;
  - the default WIDTH constant.
REQ-034 Sub-module div_addsub: combinational WIDTH+1-bit adder/subtractor with an add/sub select, shared by ITER and FIX.
REQ-035 The controller and datapath shall be in the same top module; the controller is a single registered-state FSM.

Verification
REQ-036 dividend=100, divisor=7, start pulse -> done after 19 edges, quotient=14, remainder=2, div_by_zero=0.
REQ-037 dividend=16'hFFFF, divisor=1 -> quotient=16'hFFFF, remainder=0; then dividend=5, divisor=9 back-to-back -> quotient=0, remainder=5.
REQ-038 dividend=1234, divisor=0:
  - with DIV_ZERO_DETECT_EN -> done after 2 edges, quotient=16'hFFFF, remainder=1234, div_by_zero=1;
  - without it -> done after 19 edges, same quotient and remainder, div_by_zero=0.
REQ-039 start 100/7, then clr=1 at the 8th ITER cycle -> IDLE next edge, all outputs 0, no done pulse; a following 50/5 -> quotient=10, remainder=0.
REQ-040 start 100/7, then start re-asserted with 9/3 while busy -> ignored; result is quotient=14, remainder=2.
REQ-041 Random unsigned pairs with divisor != 0, checked against a reference model -> quotient*divisor + remainder == dividend and remainder < divisor.
